// File: rtl/x_stream_src.sv
// Stimulus source for the matrix core: buffers host-written bytes and streams them
// block by block on core request, replaying a block on Xload_done, and samples result lanes.
module x_stream_src #(
    parameter int DEPTH = 160,
    parameter int BLOCK = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       go,
    output logic       start,
    input  logic       input_load_en,
    input  logic       Xload_done,
    output logic [7:0] X_load,
    output logic [1:0] P_sel,
    input  logic [8:0] P_out,
    output logic       res_valid,
    output logic [8:0] res_data,
    output logic [1:0] res_lane,
    output logic       busy,
    output logic       done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  ptr_q, ptr_d;
    logic [8:0]  base_q, base_d;
    logic [7:0]  x_load_q, x_load_d;
    logic        start_q, start_d;
    logic        phase_q, phase_d;
    logic [1:0]  p_sel_q, p_sel_d;
    logic        res_valid_q, res_valid_d;
    logic [8:0]  res_data_q, res_data_d;
    logic [1:0]  res_lane_q, res_lane_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  mem_q [DEPTH];
    logic        wr_ok_s;
    logic [7:0]  rd_byte_s;

    assign wr_ok_s   = wr_en && ({1'b0, wr_addr} < 9'(DEPTH));
    // Only meaningful while ptr < DEPTH; the end-of-buffer branch never uses it.
    assign rd_byte_s = mem_q[ptr_q[AW-1:0]];

    // Stimulus buffer; intentionally not reset so host data survives a run abort.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Next-state, stream pointer and result-capture logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        base_d      = base_q;
        x_load_d    = x_load_q;
        start_d     = start_q;
        phase_d     = 1'b0;
        p_sel_d     = p_sel_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_lane_d  = res_lane_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_STREAM;
                    ptr_d   = 9'd0;
                    base_d  = 9'd0;
                    start_d = 1'b1;
                end else begin
                    start_d = 1'b0;
                end
            end
            ST_STREAM: begin
                if (!input_load_en) begin
                    ptr_d = ptr_q;
                end else if (Xload_done) begin
                    // Replay wins over a coinciding block end: base must not advance.
                    ptr_d = base_q;
                end else if (ptr_q >= 9'(DEPTH)) begin
                    x_load_d = 8'd0;
                    state_d  = ST_DONE;
                    start_d  = 1'b0;
                end else if (ptr_q == base_q + 9'(BLOCK - 1)) begin
                    x_load_d = rd_byte_s;
                    base_d   = base_q + 9'(BLOCK);
                    ptr_d    = base_q + 9'(BLOCK);
                end else begin
                    x_load_d = rd_byte_s;
                    ptr_d    = ptr_q + 9'd1;
                end
            end
            ST_DONE: begin
                start_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase

        // Core presents a lane on P_out every other cycle while start is high.
        if (start_q) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                res_data_d  = P_out;
                res_lane_d  = p_sel_q;
                res_valid_d = 1'b1;
                p_sel_d     = p_sel_q + 2'd1;
            end else begin
                res_valid_d = 1'b0;
            end
        end else begin
            phase_d = 1'b0;
        end

        busy_d = (state_d == ST_STREAM);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 9'd0;
            base_q      <= 9'd0;
            x_load_q    <= 8'd0;
            start_q     <= 1'b0;
            phase_q     <= 1'b0;
            p_sel_q     <= 2'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 9'd0;
            res_lane_q  <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            base_q      <= base_d;
            x_load_q    <= x_load_d;
            start_q     <= start_d;
            phase_q     <= phase_d;
            p_sel_q     <= p_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_lane_q  <= res_lane_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign start     = start_q;
    assign X_load    = x_load_q;
    assign P_sel     = p_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_lane  = res_lane_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_x_stream_src.sv
// Scoreboard bench for x_stream_src: a behavioural model pushes expected outputs per
// driven cycle; they are popped and compared one time unit after the clock edge.
module tb_x_stream_src;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       go;
    logic       start;
    logic       input_load_en;
    logic       Xload_done;
    logic [7:0] X_load;
    logic [1:0] P_sel;
    logic [8:0] P_out;
    logic       res_valid;
    logic [8:0] res_data;
    logic [1:0] res_lane;
    logic       busy;
    logic       done;

    x_stream_src #(.DEPTH(160), .BLOCK(32)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .start(start), .input_load_en(input_load_en), .Xload_done(Xload_done),
        .X_load(X_load), .P_sel(P_sel), .P_out(P_out), .res_valid(res_valid),
        .res_data(res_data), .res_lane(res_lane), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] x;
        logic       st;
        logic       bz;
        logic       dn;
        logic       rv;
        logic [8:0] rd;
        logic [1:0] rl;
        logic [1:0] ps;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_rv  = 0;

    // Reference model state
    logic [7:0] mem_m [160];
    int         m_state;
    int         m_ptr;
    int         m_base;
    logic [7:0] m_x;
    logic       m_start;
    logic       m_phase;
    logic [1:0] m_psel;
    logic [8:0] m_rd;
    logic [1:0] m_rl;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_base = 0; m_x = 8'd0; m_start = 1'b0;
        m_phase = 1'b0; m_psel = 2'd0; m_rd = 9'd0; m_rl = 2'd0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_x"},     16'(X_load),    16'd0);
        check_eq({tag, "_start"}, 16'(start),     16'd0);
        check_eq({tag, "_psel"},  16'(P_sel),     16'd0);
        check_eq({tag, "_rv"},    16'(res_valid), 16'd0);
        check_eq({tag, "_rd"},    16'(res_data),  16'd0);
        check_eq({tag, "_rl"},    16'(res_lane),  16'd0);
        check_eq({tag, "_busy"},  16'(busy),      16'd0);
        check_eq({tag, "_done"},  16'(done),      16'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Drive one cycle, advance the model, push expectation, then pop and compare.
    task automatic step(input logic g, input logic rq, input logic xd, input logic [8:0] pv);
        exp_t e;
        go = g; input_load_en = rq; Xload_done = xd; P_out = pv;
        e.rv = 1'b0;
        if (m_start) begin
            if (m_phase) begin
                m_rd = pv; m_rl = m_psel; m_psel = m_psel + 2'd1; e.rv = 1'b1;
            end
            m_phase = ~m_phase;
        end else begin
            m_phase = 1'b0;
        end
        case (m_state)
            0: if (g) begin
                m_state = 1; m_ptr = 0; m_base = 0; m_start = 1'b1;
            end
            1: if (rq) begin
                if (xd) m_ptr = m_base;
                else if (m_ptr >= 160) begin
                    m_x = 8'd0; m_state = 2; m_start = 1'b0;
                end else if (m_ptr == m_base + 31) begin
                    m_x = mem_m[m_ptr]; m_base = m_base + 32; m_ptr = m_base;
                end else begin
                    m_x = mem_m[m_ptr]; m_ptr = m_ptr + 1;
                end
            end
            default: ;
        endcase
        e.x = m_x; e.st = m_start; e.bz = (m_state == 1); e.dn = (m_state == 2);
        e.rd = m_rd; e.rl = m_rl; e.ps = m_psel;
        exp_q.push_back(e);
        @(posedge clk); #1;
        go = 1'b0;
        e = exp_q.pop_front();
        if (res_valid) n_rv++;
        check_eq("x_load", 16'(X_load),    16'(e.x));
        check_eq("start",  16'(start),     16'(e.st));
        check_eq("busy",   16'(busy),      16'(e.bz));
        check_eq("done",   16'(done),      16'(e.dn));
        check_eq("res_vld",16'(res_valid), 16'(e.rv));
        check_eq("res_dat",16'(res_data),  16'(e.rd));
        check_eq("res_ln", 16'(res_lane),  16'(e.rl));
        check_eq("p_sel",  16'(P_sel),     16'(e.ps));
    endtask

    initial begin
        int n;
        logic [7:0] v;
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 8'd0; go = 1'b0;
        input_load_en = 1'b0; Xload_done = 1'b0; P_out = 9'd0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 160; i++) begin
            v = 8'(i);
            wr(v, v);
            mem_m[i] = v;
        end
        wr(8'd200, 8'hEE);

        // Result capture with static lane value, no byte requests
        step(1'b1, 1'b0, 1'b0, 9'h1A5);
        n_rv = 0;
        repeat (16) step(1'b0, 1'b0, 1'b0, 9'h1A5);
        check_eq("rv_pulses16", 16'(n_rv), 16'd8);

        // Full sweep: 160 bytes then end-of-buffer on the 161st request
        for (int i = 0; i < 161; i++) step(1'b0, 1'b1, 1'b0, 9'($urandom));
        check_eq("done_after_161", 16'(done), 16'd1);
        check_eq("x_zero_at_end", 16'(X_load), 16'd0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 9'($urandom));

        // New pattern written while in DONE must survive the reset
        for (int i = 0; i < 160; i++) begin
            v = 8'(i * 7 + 3);
            wr(8'(i), v);
            mem_m[i] = v;
        end
        #3 rst_n = 1'b0;
        #1 check_zero("rst_done");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Half-duty requests up to ptr 37, then replay
        step(1'b1, 1'b0, 1'b0, 9'($urandom));
        n = 0;
        while (m_ptr != 37 && n < 400) begin
            step(1'b0, (n % 2) == 0, 1'b0, 9'($urandom));
            n++;
        end
        check_eq("reach37_bound", 16'(n < 400), 16'd1);
        step(1'b0, 1'b1, 1'b1, 9'($urandom));
        check_eq("replay_hold36", 16'(X_load), 16'(mem_m[36]));
        step(1'b0, 1'b1, 1'b0, 9'($urandom));
        check_eq("replay_next32", 16'(X_load), 16'(mem_m[32]));

        // Replay coincident with block end at ptr 63
        n = 0;
        while (m_ptr != 63 && n < 400) begin
            step(1'b0, 1'b1, 1'b0, 9'($urandom));
            n++;
        end
        check_eq("reach63_bound", 16'(n < 400), 16'd1);
        step(1'b0, 1'b1, 1'b1, 9'($urandom));
        check_eq("blkend_hold62", 16'(X_load), 16'(mem_m[62]));
        step(1'b0, 1'b1, 1'b0, 9'($urandom));
        check_eq("blkend_next32", 16'(X_load), 16'(mem_m[32]));

        // Random duty up to ptr 70, then abort with reset
        n = 0;
        while (m_ptr != 70 && n < 800) begin
            step(1'b0, 1'($urandom), 1'b0, 9'($urandom));
            n++;
        end
        check_eq("reach70_bound", 16'(n < 800), 16'd1);
        check_eq("busy_at70", 16'(busy), 16'd1);
        #3 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        step(1'b1, 1'b0, 1'b0, 9'($urandom));
        step(1'b0, 1'b1, 1'b0, 9'($urandom));
        check_eq("restart_byte0", 16'(X_load), 16'(mem_m[0]));
        repeat (6) step(1'b0, 1'b1, 1'b0, 9'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
